// File: rtl/capsense_scan_ctrl.sv
// capsense_scan_ctrl: N-channel capacitive pad scanner.
// Each scan discharges every pad, then times how long each pad takes to charge
// back up. A pad still low after THRESHOLD sample ticks reads as touched. The
// result is debounced across scans and presented per channel either directly
// or as a toggle bit, together with press/change strobes.
module capsense_scan_ctrl #(
    parameter int FREQUENCY  = 24,
    parameter int SAMP_KHZ   = 1500,
    parameter int N          = 4,
    parameter int POLL_TICKS = 131072,
    parameter int DISCHARGE  = 4,
    parameter int THRESHOLD  = 8,
    parameter int DEBOUNCE   = 3
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         ena_i,
    input  logic [N-1:0] mode_i,
    input  logic         clr_i,
    input  logic [N-1:0] capsense_i,
    output logic         capsense_o,
    output logic [N-1:0] buttons_o,
    output logic [N-1:0] raw_o,
    output logic [N-1:0] press_o,
    output logic         changed_o,
    output logic [N-1:0] debug_o
);

    localparam int MOD_SAMP = FREQUENCY * 1000 / SAMP_KHZ;
    localparam int SW       = $clog2(MOD_SAMP);
    localparam int PLW      = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;
    localparam int PH_MAX   = (DISCHARGE > THRESHOLD) ? DISCHARGE : THRESHOLD;
    localparam int PHW      = $clog2(PH_MAX + 1);
    localparam int DW       = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

    localparam logic [SW-1:0]  SAMP_LAST = SW'(MOD_SAMP - 1);
    localparam logic [PLW-1:0] POLL_LAST = PLW'(POLL_TICKS - 1);
    localparam logic [PHW-1:0] DIS_LAST  = PHW'(DISCHARGE - 1);
    localparam logic [PHW-1:0] THR_LAST  = PHW'(THRESHOLD - 1);
    localparam logic [DW-1:0]  DB_LAST   = DW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISCH,
        ST_MEAS,
        ST_UPD
    } state_t;

    state_t                 state_q, state_d;
    logic [SW-1:0]          samp_cnt_q, samp_cnt_d;
    logic [PLW-1:0]         poll_cnt_q, poll_cnt_d;
    logic [PHW-1:0]         ph_cnt_q, ph_cnt_d;
    logic [N-1:0]           done_q, done_d;
    logic [N-1:0]           sync1_q, sync2_q;
    logic [N-1:0]           raw_q, raw_d;
    logic [N-1:0]           stable_q, stable_d;
    logic [N-1:0]           tog_q, tog_d;
    logic [N-1:0][DW-1:0]   dcnt_q, dcnt_d;
    logic [N-1:0]           press_q, press_d;
    logic                   changed_q, changed_d;
    logic [N-1:0]           buttons_q, buttons_d;

    logic                   samp_tick;
    logic                   poll_tick;
    logic [N-1:0]           done_upd;

    // Sample-tick prescaler and poll-period counter (counts sample ticks).
    always_comb begin
        samp_tick  = (samp_cnt_q == SAMP_LAST);
        poll_tick  = samp_tick && (poll_cnt_q == POLL_LAST);
        samp_cnt_d = samp_tick ? '0 : samp_cnt_q + 1'b1;
        poll_cnt_d = poll_cnt_q;
        if (samp_tick) begin
            poll_cnt_d = poll_tick ? '0 : poll_cnt_q + 1'b1;
        end
    end

    // Scan sequencer: discharge, timed measure, one-cycle result update.
    always_comb begin
        state_d  = state_q;
        ph_cnt_d = ph_cnt_q;
        done_d   = done_q;
        done_upd = done_q | sync2_q;
        unique case (state_q)
            ST_IDLE: begin
                if (poll_tick && ena_i) begin
                    state_d  = ST_DISCH;
                    ph_cnt_d = '0;
                    done_d   = '0;
                end
            end
            ST_DISCH: begin
                if (samp_tick) begin
                    if (ph_cnt_q == DIS_LAST) begin
                        state_d  = ST_MEAS;
                        ph_cnt_d = '0;
                    end else begin
                        ph_cnt_d = ph_cnt_q + 1'b1;
                    end
                end
            end
            ST_MEAS: begin
                if (samp_tick) begin
                    done_d = done_upd;
                    if ((&done_upd) || (ph_cnt_q == THR_LAST)) begin
                        state_d  = ST_UPD;
                        ph_cnt_d = '0;
                    end else begin
                        ph_cnt_d = ph_cnt_q + 1'b1;
                    end
                end
            end
            ST_UPD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Per-channel debounce, toggle tracking, strobes and output selection.
    always_comb begin
        raw_d     = raw_q;
        stable_d  = stable_q;
        dcnt_d    = dcnt_q;
        tog_d     = tog_q;
        press_d   = '0;
        changed_d = 1'b0;
        if (state_q == ST_UPD) begin
            // pads that never charged within the window are the touched ones
            raw_d = ~done_q;
            for (int unsigned i = 0; i < N; i++) begin
                if (raw_d[i] == stable_q[i]) begin
                    dcnt_d[i] = '0;
                end else if (dcnt_q[i] == DB_LAST) begin
                    stable_d[i] = ~stable_q[i];
                    dcnt_d[i]   = '0;
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end
            press_d   = stable_d & ~stable_q;
            changed_d = |(stable_d ^ stable_q);
            tog_d     = tog_q ^ press_d;
        end
        // clear wins over a toggle in the same cycle
        if (clr_i) begin
            tog_d = '0;
        end
        buttons_d = (mode_i & tog_q) | (~mode_i & stable_q);
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            samp_cnt_q <= '0;
            poll_cnt_q <= '0;
            ph_cnt_q   <= '0;
            done_q     <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            raw_q      <= '0;
            stable_q   <= '0;
            tog_q      <= '0;
            dcnt_q     <= '0;
            press_q    <= '0;
            changed_q  <= 1'b0;
            buttons_q  <= '0;
        end else begin
            state_q    <= state_d;
            samp_cnt_q <= samp_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            ph_cnt_q   <= ph_cnt_d;
            done_q     <= done_d;
            sync1_q    <= capsense_i;
            sync2_q    <= sync1_q;
            raw_q      <= raw_d;
            stable_q   <= stable_d;
            tog_q      <= tog_d;
            dcnt_q     <= dcnt_d;
            press_q    <= press_d;
            changed_q  <= changed_d;
            buttons_q  <= buttons_d;
        end
    end

    // Pad drive and debug decode straight from the state register so that
    // reset removes them without waiting for a clock edge.
    always_comb begin
        capsense_o = (state_q == ST_DISCH);
        debug_o    = (state_q == ST_MEAS) ? ~done_q : '0;
        buttons_o  = buttons_q;
        raw_o      = raw_q;
        press_o    = press_q;
        changed_o  = changed_q;
    end

endmodule

// File: tb/tb_capsense_scan_ctrl.sv
// Bench for capsense_scan_ctrl: directed scans with hand-computed results,
// checked by a monitor against a scoreboard queue.
module tb_capsense_scan_ctrl;

    localparam int N     = 4;
    localparam int RISE  = 32;    // pad charge-up delay after release, clk
    localparam int BOUND = 2500;  // max cycles waited on any DUT event

    logic         clk;
    logic         rst_n_i;
    logic         ena_i;
    logic [N-1:0] mode_i;
    logic         clr_i;
    logic [N-1:0] capsense_i;
    logic         capsense_o;
    logic [N-1:0] buttons_o;
    logic [N-1:0] raw_o;
    logic [N-1:0] press_o;
    logic         changed_o;
    logic [N-1:0] debug_o;

    logic [N-1:0] touch = '0;
    int           n_checks = 0;
    int           n_fail = 0;
    bit           stim_done = 0;

    typedef struct {
        logic [N-1:0] touch;
        logic [N-1:0] mode;
        bit           clr;
        logic [N-1:0] raw;
        logic [N-1:0] press;
        logic         chg;
        logic [N-1:0] btn;
        int           mlen;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    capsense_scan_ctrl #(
        .FREQUENCY (24),
        .SAMP_KHZ  (1500),
        .N         (N),
        .POLL_TICKS(64),
        .DISCHARGE (4),
        .THRESHOLD (8),
        .DEBOUNCE  (3)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n_i),
        .ena_i     (ena_i),
        .mode_i    (mode_i),
        .clr_i     (clr_i),
        .capsense_i(capsense_i),
        .capsense_o(capsense_o),
        .buttons_o (buttons_o),
        .raw_o     (raw_o),
        .press_o   (press_o),
        .changed_o (changed_o),
        .debug_o   (debug_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got no event within %0d cycles, expected one (t=%0t)", name, BOUND, $time);
    endtask

    // Untouched pads measure 3 ticks (48 clk); any touched pad runs to 8 ticks.
    task automatic add(input logic [N-1:0] t, input logic [N-1:0] m, input bit c,
                       input logic [N-1:0] r, input logic [N-1:0] p, input logic ch,
                       input logic [N-1:0] b);
        vec_t v;
        v.touch = t; v.mode = m; v.clr = c;
        v.raw = r; v.press = p; v.chg = ch; v.btn = b;
        v.mlen = (t == '0) ? 48 : 128;
        vecs.push_back(v);
    endtask

    task automatic wait_cap(input logic lvl, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (capsense_o !== lvl && n < BOUND);
        if (capsense_o !== lvl) timeout(name);
    endtask

    task automatic wait_dbg0();
        int n;
        n = 0;
        while (debug_o != '0 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (debug_o != '0) timeout("stim_measure_end");
    endtask

    // Pad model: held low while driven, touched pads stay low, others rise RISE clk after release.
    initial begin : pads
        int rc;
        rc = RISE;
        capsense_i = '0;
        forever begin
            @(negedge clk);
            if (capsense_o) begin
                rc = 0;
                capsense_i = '0;
            end else begin
                if (rc < RISE) rc++;
                capsense_i = (rc >= RISE) ? ~touch : '0;
            end
        end
    end

    // Monitor: times each scan and checks results after its update cycle.
    initial begin : monitor
        vec_t e;
        int   n;
        while (1) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                if (stim_done) break;
                continue;
            end
            e = sb.pop_front();
            n = 0;
            while (!capsense_o && n < BOUND) begin
                @(negedge clk);
                n++;
            end
            if (!capsense_o) begin
                timeout("scan_start");
                continue;
            end
            n = 0;
            while (capsense_o && n < BOUND) begin
                n++;
                @(negedge clk);
            end
            chk("discharge_len", n, 64);
            n = 0;
            while (debug_o != '0 && n < BOUND) begin
                n++;
                @(negedge clk);
            end
            chk("measure_len", n, e.mlen);
            @(negedge clk);
            chk("raw_o", raw_o, e.raw);
            chk("press_o", press_o, e.press);
            chk("changed_o", changed_o, e.chg);
            @(negedge clk);
            chk("press_one_cycle", press_o, 0);
            chk("changed_one_cycle", changed_o, 0);
            chk("buttons_o", buttons_o, e.btn);
        end
    end

    initial begin : stim
        int n;
        rst_n_i = 1'b0;
        ena_i   = 1'b1;
        clr_i   = 1'b0;
        mode_i  = '0;

        //   touch    mode     clr  raw      press    chg   btn
        add(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        add(4'b0010, 4'b0000, 0, 4'b0010, 4'b0000, 1'b0, 4'b0000);
        add(4'b0010, 4'b0000, 0, 4'b0010, 4'b0000, 1'b0, 4'b0000);
        add(4'b0010, 4'b0000, 0, 4'b0010, 4'b0010, 1'b1, 4'b0010);
        add(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 1'b0, 4'b0010);
        add(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 1'b0, 4'b0010);
        add(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 1'b1, 4'b0000);
        add(4'b0010, 4'b0000, 0, 4'b0010, 4'b0000, 1'b0, 4'b0000);
        add(4'b0010, 4'b0000, 0, 4'b0010, 4'b0000, 1'b0, 4'b0000);
        add(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        add(4'b0010, 4'b0000, 0, 4'b0010, 4'b0000, 1'b0, 4'b0000);
        add(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        add(4'b0001, 4'b0001, 0, 4'b0001, 4'b0000, 1'b0, 4'b0000);
        add(4'b0001, 4'b0001, 0, 4'b0001, 4'b0000, 1'b0, 4'b0000);
        add(4'b0001, 4'b0001, 0, 4'b0001, 4'b0001, 1'b1, 4'b0001);
        add(4'b0000, 4'b0001, 0, 4'b0000, 4'b0000, 1'b0, 4'b0001);
        add(4'b0000, 4'b0001, 0, 4'b0000, 4'b0000, 1'b0, 4'b0001);
        add(4'b0000, 4'b0001, 0, 4'b0000, 4'b0000, 1'b1, 4'b0001);
        add(4'b0001, 4'b0001, 0, 4'b0001, 4'b0000, 1'b0, 4'b0001);
        add(4'b0001, 4'b0001, 0, 4'b0001, 4'b0000, 1'b0, 4'b0001);
        add(4'b0001, 4'b0001, 0, 4'b0001, 4'b0001, 1'b1, 4'b0000);
        add(4'b0000, 4'b0001, 0, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        add(4'b0000, 4'b0001, 0, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        add(4'b0000, 4'b0001, 0, 4'b0000, 4'b0000, 1'b1, 4'b0000);
        add(4'b0001, 4'b0001, 0, 4'b0001, 4'b0000, 1'b0, 4'b0000);
        add(4'b0001, 4'b0001, 0, 4'b0001, 4'b0000, 1'b0, 4'b0000);
        add(4'b0001, 4'b0001, 1, 4'b0001, 4'b0001, 1'b1, 4'b0000);
        add(4'b0001, 4'b0000, 0, 4'b0001, 4'b0000, 1'b0, 4'b0001);
        add(4'b1001, 4'b0000, 0, 4'b1001, 4'b0000, 1'b0, 4'b0001);
        add(4'b1001, 4'b0000, 0, 4'b1001, 4'b0000, 1'b0, 4'b0001);
        add(4'b1001, 4'b0000, 0, 4'b1001, 4'b1000, 1'b1, 4'b1001);

        repeat (3) @(negedge clk);
        chk("rst_capsense_o", capsense_o, 0);
        chk("rst_buttons_o", buttons_o, 0);
        chk("rst_raw_o", raw_o, 0);
        chk("rst_press_o", press_o, 0);
        chk("rst_changed_o", changed_o, 0);
        chk("rst_debug_o", debug_o, 0);
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_capsense_o", capsense_o, 0);
        chk("post_rst_buttons_o", buttons_o, 0);

        foreach (vecs[k]) begin
            touch  = vecs[k].touch;
            mode_i = vecs[k].mode;
            sb.push_back(vecs[k]);
            wait_cap(1'b1, "stim_scan_start");
            wait_cap(1'b0, "stim_discharge_end");
            wait_dbg0();
            if (vecs[k].clr) begin
                clr_i = 1'b1;
                @(negedge clk);
                clr_i = 1'b0;
            end
            repeat (4) @(negedge clk);
        end

        n = 0;
        while (sb.size() != 0 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) timeout("scoreboard_drain");
        stim_done = 1;

        // Reset in the middle of a measure window.
        wait_cap(1'b1, "mid_rst_scan_start");
        wait_cap(1'b0, "mid_rst_discharge_end");
        repeat (10) @(negedge clk);
        chk("mid_meas_debug_o", debug_o, 4'b1111);
        chk("mid_meas_buttons_o", buttons_o, 4'b1001);
        rst_n_i = 1'b0;
        #1;
        chk("async_rst_capsense_o", capsense_o, 0);
        chk("async_rst_debug_o", debug_o, 0);
        chk("async_rst_buttons_o", buttons_o, 0);
        chk("async_rst_raw_o", raw_o, 0);
        @(negedge clk);
        rst_n_i = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!capsense_o && n < BOUND);
        chk("restart_on_poll_tick", n, 1024);
        chk("restart_buttons_o", buttons_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
